// File: rtl/wb_region_mux_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_region_mux_if
// Brief    : Wishbone request side plus downstream valid/ready slave bundle.
// Revision : 1.0
// ============================================================================
interface wb_region_mux_if #(
   parameter int N_SLV = 4,
   parameter int AW    = 32,
   parameter int DW    = 32
);
   logic                wbs_cyc_i;
   logic                wbs_stb_i;
   logic                wbs_we_i;
   logic [3:0]          wbs_sel_i;
   logic [AW-1:0]       wbs_adr_i;
   logic [DW-1:0]       wbs_dat_i;
   logic                wbs_ack_o;
   logic                wbs_err_o;
   logic [DW-1:0]       wbs_dat_o;
   logic [N_SLV-1:0]    s_valid_o;
   logic                s_we_o;
   logic [3:0]          s_sel_o;
   logic [AW-1:0]       s_adr_o;
   logic [DW-1:0]       s_wdata_o;
   logic [N_SLV-1:0]    s_ready_i;
   logic [N_SLV*DW-1:0] s_rdata_i;

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_err_o, wbs_dat_o,
      output s_valid_o, s_we_o, s_sel_o, s_adr_o, s_wdata_o,
      input  s_ready_i, s_rdata_i
   );

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_err_o, wbs_dat_o,
      input  s_valid_o, s_we_o, s_sel_o, s_adr_o, s_wdata_o,
      output s_ready_i, s_rdata_i
   );
endinterface
`default_nettype wire

// File: rtl/wb_region_mux.sv
`default_nettype none
// ============================================================================
// Module   : wb_region_mux
// Brief    : Wishbone router to N programmable address regions with timeout,
//            unmapped-address error response and error statistics.
// Revision : 1.0
// ============================================================================
module wb_region_mux #(
   parameter int                  N_SLV        = 4,
   parameter int                  AW           = 32,
   parameter int                  DW           = 32,
   parameter logic [N_SLV*AW-1:0] BASE         = '0,
   parameter logic [N_SLV*AW-1:0] MASK         = '1,
   parameter int                  TIMEOUT      = 255,
   parameter logic [DW-1:0]       DEFAULT_DATA = 'hDEADBEEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   wb_region_mux_if.slave       bus,
   output logic [15:0]          err_cnt_o,
   output logic [AW-1:0]        last_err_adr_o
);

   localparam int              c_IW        = (N_SLV > 1) ? $clog2(N_SLV) : 1;
   localparam int              c_TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [c_TW-1:0] c_WAIT_LAST = c_TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t              r_state, w_state;
   logic [c_IW-1:0]     r_idx, w_idx, w_hit_idx;
   logic                w_hit;
   logic [c_TW-1:0]     r_wait, w_wait;
   logic [AW-1:0]       r_adr, w_adr;
   logic [DW-1:0]       r_wdata, w_wdata;
   logic                r_we, w_we;
   logic [3:0]          r_sel, w_sel;
   logic [N_SLV-1:0]    r_valid, w_valid;
   logic                r_ack, w_ack;
   logic                r_err, w_err;
   logic [DW-1:0]       r_dat, w_dat;
   logic [15:0]         r_err_cnt, w_err_cnt;
   logic [AW-1:0]       r_last_err_adr, w_last_err_adr;
   logic                w_cnt_err;
   logic [AW-1:0]       w_err_adr;
   logic                w_sel_ready;
   logic [DW-1:0]       w_sel_rdata;

   // Scan high to low so the lowest matching region index wins on overlap.
   always_comb begin
      w_hit     = 1'b0;
      w_hit_idx = '0;
      for (int i = N_SLV - 1; i >= 0; i--) begin
         if ((bus.wbs_adr_i & MASK[i*AW +: AW]) == BASE[i*AW +: AW]) begin
            w_hit     = 1'b1;
            w_hit_idx = c_IW'(i);
         end
      end
   end

   always_comb begin
      w_sel_ready = 1'b0;
      w_sel_rdata = '0;
      for (int i = 0; i < N_SLV; i++) begin
         if (r_idx == c_IW'(i)) begin
            w_sel_ready = bus.s_ready_i[i];
            w_sel_rdata = bus.s_rdata_i[i*DW +: DW];
         end
      end
   end

   always_comb begin
      w_state        = r_state;
      w_idx          = r_idx;
      w_wait         = r_wait;
      w_adr          = r_adr;
      w_wdata        = r_wdata;
      w_we           = r_we;
      w_sel          = r_sel;
      w_valid        = '0;
      w_ack          = 1'b0;
      w_err          = 1'b0;
      w_dat          = '0;
      w_err_cnt      = r_err_cnt;
      w_last_err_adr = r_last_err_adr;
      w_cnt_err      = 1'b0;
      w_err_adr      = r_adr;

      case (r_state)
         S_IDLE: begin
            if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
               w_adr   = bus.wbs_adr_i;
               w_wdata = bus.wbs_dat_i;
               w_we    = bus.wbs_we_i;
               w_sel   = bus.wbs_sel_i & {4{bus.wbs_we_i}};
               if (w_hit) begin
                  w_idx              = w_hit_idx;
                  w_wait             = '0;
                  w_valid[w_hit_idx] = 1'b1;
                  w_state            = S_ACCESS;
               end else begin
                  w_ack     = 1'b1;
                  w_err     = 1'b1;
                  w_dat     = DEFAULT_DATA;
                  w_cnt_err = 1'b1;
                  w_err_adr = bus.wbs_adr_i;
                  w_state   = S_RESP;
               end
            end
         end
         S_ACCESS: begin
            if (!bus.wbs_cyc_i) begin
               w_state = S_IDLE;
            end else if (w_sel_ready) begin
               w_ack   = 1'b1;
               w_dat   = r_we ? '0 : w_sel_rdata;
               w_state = S_RESP;
            end else if ((TIMEOUT != 0) && (r_wait == c_WAIT_LAST)) begin
               w_ack     = 1'b1;
               w_err     = 1'b1;
               w_dat     = DEFAULT_DATA;
               w_cnt_err = 1'b1;
               w_state   = S_RESP;
            end else begin
               w_wait  = r_wait + c_TW'(1);
               w_valid = r_valid;
            end
         end
         S_RESP:  w_state = S_IDLE;
         default: w_state = S_IDLE;
      endcase

      if (w_cnt_err) begin
         if (r_err_cnt != 16'hFFFF) begin
            w_err_cnt = r_err_cnt + 16'd1;
         end
         w_last_err_adr = w_err_adr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= S_IDLE;
         r_idx          <= '0;
         r_wait         <= '0;
         r_adr          <= '0;
         r_wdata        <= '0;
         r_we           <= 1'b0;
         r_sel          <= '0;
         r_valid        <= '0;
         r_ack          <= 1'b0;
         r_err          <= 1'b0;
         r_dat          <= '0;
         r_err_cnt      <= '0;
         r_last_err_adr <= '0;
      end else begin
         r_state        <= w_state;
         r_idx          <= w_idx;
         r_wait         <= w_wait;
         r_adr          <= w_adr;
         r_wdata        <= w_wdata;
         r_we           <= w_we;
         r_sel          <= w_sel;
         r_valid        <= w_valid;
         r_ack          <= w_ack;
         r_err          <= w_err;
         r_dat          <= w_dat;
         r_err_cnt      <= w_err_cnt;
         r_last_err_adr <= w_last_err_adr;
      end
   end

   assign bus.wbs_ack_o  = r_ack;
   assign bus.wbs_err_o  = r_err;
   assign bus.wbs_dat_o  = r_dat;
   assign bus.s_valid_o  = r_valid;
   assign bus.s_we_o     = r_we;
   assign bus.s_sel_o    = r_sel;
   assign bus.s_adr_o    = r_adr;
   assign bus.s_wdata_o  = r_wdata;
   assign err_cnt_o      = r_err_cnt;
   assign last_err_adr_o = r_last_err_adr;

endmodule
`default_nettype wire
